// File: rtl/svi_pkg.sv
// Shared types and constants for the SVI-328 ioctl download writer.
//   ROM_IDX_MAX : ioctl indices below this value are ROM images (0 = BIOS, 1 = cart)
//   dl_entry_t  : one buffered download byte {bank, address, data}
//   wr_state_e  : states of the SDRAM write sequencer
//   sat_inc17   : 17-bit increment that sticks at the maximum value
package svi_pkg;

  localparam int ROM_IDX_MAX = 2;

  typedef struct packed {
    logic        bank;
    logic [15:0] a;
    logic [7:0]  d;
  } dl_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } wr_state_e;

  function automatic logic [16:0] sat_inc17(input logic [16:0] v);
    return (v == 17'h1FFFF) ? v : v + 17'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered read port.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   push_i, din_i    : write strobe and data (ignored when full)
//   pop_i            : read strobe; dout_o shows the popped entry from the next cycle on
//   dout_o           : registered read data, stable until the next pop
//   count_o          : number of stored entries (0..DEPTH)
//   full_o, empty_o  : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic [WIDTH-1:0] dout_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == FULL_C);
  assign empty_o   = (count_q == {(PW+1){1'b0}});
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign dout_o    = dout_q;
  assign count_o   = count_q;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers (wrap naturally at power-of-two DEPTH), count and read register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {(PW+1){1'b0}};
      dout_q   <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q   <= mem_q[rd_ptr_q];
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/svi_ioctl_sdram_writer.sv
// Buffers HPS ioctl download bytes and writes them into the SVI-328 SDRAM image
// at {index[0], addr[15:0]}, yielding to Z80 RAM-mapper accesses at all times.
//   dl_*_i / dl_wait_o : ioctl download interface from hps_io, with throttle
//   cpu_*_i            : mapper RAM request, passed straight through when idle
//   sd_*               : SDRAM command interface
//   busy_o  : FIFO non-empty or a write still in flight
//   done_o  : one-cycle pulse once a finished download is fully committed
//   ovf_o   : sticky drop flag (out-of-range address or push while full)
//   bytes_o : bytes committed in the current download (saturating)
module svi_ioctl_sdram_writer
  import svi_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AFULL = 2,
  parameter int AW    = 18
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          dl_active_i,
  input  logic [7:0]    dl_index_i,
  input  logic          dl_wr_i,
  input  logic [24:0]   dl_addr_i,
  input  logic [7:0]    dl_data_i,
  output logic          dl_wait_o,
  input  logic          cpu_rd_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [7:0]    cpu_data_i,
  input  logic          sd_rdy_i,
  output logic [AW-1:0] sd_addr_o,
  output logic [7:0]    sd_din_o,
  output logic          sd_we_o,
  output logic          sd_rd_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          ovf_o,
  output logic [16:0]   bytes_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  wr_state_e   state_q, state_d;
  logic        wait_q, wait_d;
  logic        act_prev_q;
  logic        seen_q, seen_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [16:0] bytes_q, bytes_d;

  dl_entry_t   entry_in_s;
  dl_entry_t   hold_s;
  logic        idx_ok_s, addr_ok_s, wr_ok_s, push_s, pop_s, commit_s;
  logic        ovf_set_s, cpu_req_s, rise_s, end_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s, count_nxt_s;
  logic [16:0] bytes_base_s;
  logic        unused_s;

  assign unused_s   = ^dl_index_i[7:6];
  assign idx_ok_s   = dl_index_i[5:0] < 6'(ROM_IDX_MAX);
  assign addr_ok_s  = (dl_addr_i[24:16] == 9'd0);
  assign wr_ok_s    = dl_wr_i & dl_active_i & idx_ok_s;
  assign push_s     = wr_ok_s & addr_ok_s & ~fifo_full_s;
  assign ovf_set_s  = wr_ok_s & (~addr_ok_s | fifo_full_s);
  assign cpu_req_s  = cpu_rd_i | cpu_we_i;
  assign rise_s     = dl_active_i & ~act_prev_q;
  assign entry_in_s = '{bank: dl_index_i[0], a: dl_addr_i[15:0], d: dl_data_i};

  sync_fifo #(
    .WIDTH($bits(dl_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (push_s),
    .din_i    (entry_in_s),
    .pop_i    (pop_s),
    .dout_o   (hold_s),
    .count_o  (fifo_count_s),
    .full_o   (fifo_full_s),
    .empty_o  (fifo_empty_s)
  );

  // Write sequencer: start a write only when the CPU is not asking for SDRAM.
  always_comb begin
    state_d  = state_q;
    pop_s    = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s && sd_rdy_i && !cpu_req_s) begin
          state_d = ISSUE;
          pop_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sd_rdy_i) begin
          commit_s = 1'b1;
          if (!fifo_empty_s && !cpu_req_s) begin
            state_d = ISSUE;
            pop_s   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SDRAM mux: hold register owns the bus during ISSUE/WAIT, the CPU otherwise.
  // Strobes are gated by reset so nothing is written while reset is low.
  always_comb begin
    sd_addr_o = cpu_addr_i;
    sd_din_o  = cpu_data_i;
    sd_we_o   = 1'b0;
    sd_rd_o   = 1'b0;
    if (state_q == ISSUE || state_q == WAIT) begin
      sd_addr_o = AW'({hold_s.bank, hold_s.a});
      sd_din_o  = hold_s.d;
      sd_we_o   = (state_q == ISSUE) & reset_n_i;
    end else begin
      sd_we_o = cpu_we_i & reset_n_i;
      sd_rd_o = cpu_rd_i & reset_n_i;
    end
  end

  // Status next-state: counters restart on a new download, end flag latches.
  always_comb begin
    count_nxt_s  = fifo_count_s + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    // Throttle from the next count so dl_wait_o tracks the occupancy exactly.
    wait_d       = (count_nxt_s >= CW'(DEPTH - AFULL));
    bytes_base_s = rise_s ? 17'd0 : bytes_q;
    if (commit_s) begin
      bytes_d = sat_inc17(bytes_base_s);
    end else begin
      bytes_d = bytes_base_s;
    end
    ovf_d = (rise_s ? 1'b0 : ovf_q) | ovf_set_s;
    end_s = ~dl_active_i & seen_q & fifo_empty_s & (state_q == IDLE);
    if (dl_active_i) begin
      seen_d = 1'b1;
    end else if (end_s) begin
      seen_d = 1'b0;
    end else begin
      seen_d = seen_q;
    end
    done_d = end_s;
  end

  // State and status registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      wait_q     <= 1'b0;
      act_prev_q <= 1'b0;
      seen_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bytes_q    <= 17'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      act_prev_q <= dl_active_i;
      seen_q     <= seen_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bytes_q    <= bytes_d;
    end
  end

  assign dl_wait_o = ~reset_n_i | wait_q;
  assign busy_o    = ~fifo_empty_s | (state_q != IDLE);
  assign done_o    = done_q;
  assign ovf_o     = ovf_q;
  assign bytes_o   = bytes_q;

endmodule

// File: tb/tb_svi_ioctl_sdram_writer.sv
// Directed self-checking bench for svi_ioctl_sdram_writer.
module tb_svi_ioctl_sdram_writer;

  logic        clk;
  logic        reset_n;
  logic        dl_active;
  logic [7:0]  dl_index;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait_o;
  logic        cpu_rd, cpu_we;
  logic [17:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        sd_rdy;
  logic [17:0] sd_addr_o;
  logic [7:0]  sd_din_o;
  logic        sd_we_o, sd_rd_o;
  logic        busy_o, done_o, ovf_o;
  logic [16:0] bytes_o;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [25:0] wr_q [$];

  svi_ioctl_sdram_writer #(.DEPTH(8), .AFULL(2), .AW(18)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .dl_active_i(dl_active), .dl_index_i(dl_index),
    .dl_wr_i(dl_wr), .dl_addr_i(dl_addr), .dl_data_i(dl_data), .dl_wait_o(dl_wait_o),
    .cpu_rd_i(cpu_rd), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data),
    .sd_rdy_i(sd_rdy), .sd_addr_o(sd_addr_o), .sd_din_o(sd_din_o), .sd_we_o(sd_we_o),
    .sd_rd_o(sd_rd_o), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o), .bytes_o(bytes_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every SDRAM write strobe and count done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (sd_we_o === 1'b1) wr_q.push_back({sd_addr_o, sd_din_o});
    if (done_o === 1'b1) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    dl_index = idx; dl_addr = addr; dl_data = data; dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
  endtask

  // Behaves like hps_io: holds off while dl_wait_o is high (bounded).
  task automatic send_thr(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    for (int n = 0; n < 200 && dl_wait_o; n++) tick();
    send_byte(idx, addr, data);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 400 && busy_o; n++) tick();
    check_eq(tag, {31'd0, busy_o}, 32'd0);
    tick(); tick();
  endtask

  task automatic new_download(input logic [7:0] idx);
    dl_active = 1'b0; tick(); tick();
    dl_index = idx; dl_active = 1'b1; tick();
  endtask

  function automatic logic [25:0] wr_at(input int i);
    return (i < wr_q.size()) ? wr_q[i] : 26'h3FFFFFF;
  endfunction

  initial begin
    int cpu_cnt, fifo_cnt, fifo_after;
    logic [25:0] e;
    reset_n = 1'b0; dl_active = 1'b0; dl_index = 8'd0; dl_wr = 1'b0; dl_addr = 25'd0;
    dl_data = 8'd0; cpu_rd = 1'b0; cpu_we = 1'b0; cpu_addr = 18'd0; cpu_data = 8'd0;
    sd_rdy = 1'b1;
    tick(); tick(); tick();
    // Reset state
    check_eq("rst_wait", {31'd0, dl_wait_o}, 32'd1);
    check_eq("rst_we",   {31'd0, sd_we_o},   32'd0);
    check_eq("rst_busy", {31'd0, busy_o},    32'd0);
    check_eq("rst_done", {31'd0, done_o},    32'd0);
    check_eq("rst_ovf",  {31'd0, ovf_o},     32'd0);
    check_eq("rst_bytes", {15'd0, bytes_o},  32'd0);
    reset_n = 1'b1; tick();
    check_eq("rel_wait", {31'd0, dl_wait_o}, 32'd0);

    // 1: index 1, 16 bytes, SDRAM always ready
    wr_q.delete();
    new_download(8'd1);
    for (int i = 0; i < 16; i++) send_thr(8'd1, 25'(i), 8'hA0 + 8'(i));
    drain("t1_drain");
    check_eq("t1_nwr", wr_q.size(), 32'd16);
    for (int i = 0; i < 16; i++)
      check_eq("t1_wr", {6'd0, wr_at(i)}, {6'd0, 18'h10000 + 18'(i), 8'hA0 + 8'(i)});
    check_eq("t1_bytes", {15'd0, bytes_o}, 32'd16);
    check_eq("t1_ovf", {31'd0, ovf_o}, 32'd0);
    check_eq("t1_nodone_early", done_cnt, 32'd0);
    dl_active = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    check_eq("t1_done_once", done_cnt, 32'd1);

    // 2: SDRAM stalled for 40 cycles mid-burst, throttle at count 6
    wr_q.delete();
    sd_rdy = 1'b0;
    new_download(8'd0);
    for (int i = 0; i < 5; i++) send_thr(8'd0, 25'h100 + 25'(i), 8'h30 + 8'(i));
    check_eq("t2_wait_lo5", {31'd0, dl_wait_o}, 32'd0);
    send_thr(8'd0, 25'h105, 8'h35);
    check_eq("t2_wait_hi6", {31'd0, dl_wait_o}, 32'd1);
    check_eq("t2_count6", {28'd0, dut.u_fifo.count_o}, 32'd6);
    for (int n = 0; n < 34; n++) tick();
    check_eq("t2_wait_held", {31'd0, dl_wait_o}, 32'd1);
    check_eq("t2_nowr_stall", wr_q.size(), 32'd0);
    sd_rdy = 1'b1;
    for (int i = 6; i < 10; i++) send_thr(8'd0, 25'h100 + 25'(i), 8'h30 + 8'(i));
    drain("t2_drain");
    check_eq("t2_nwr", wr_q.size(), 32'd10);
    for (int i = 0; i < 10; i++)
      check_eq("t2_wr", {6'd0, wr_at(i)}, {6'd0, 18'h00100 + 18'(i), 8'h30 + 8'(i)});
    check_eq("t2_ovf", {31'd0, ovf_o}, 32'd0);
    check_eq("t2_bytes", {15'd0, bytes_o}, 32'd10);

    // 3: CPU write during a FIFO drain takes the bus, drain resumes afterwards
    wr_q.delete();
    new_download(8'd1);
    for (int i = 0; i < 4; i++) send_byte(8'd1, 25'h40 + 25'(i), 8'hC0 + 8'(i));
    cpu_addr = 18'h2ABCD; cpu_data = 8'h5A; cpu_we = 1'b1;
    tick(); tick(); tick(); tick();
    cpu_we = 1'b0;
    drain("t3_drain");
    cpu_cnt = 0; fifo_cnt = 0; fifo_after = 0;
    foreach (wr_q[k]) begin
      e = wr_q[k];
      if (e[25:8] == 18'h2ABCD) begin
        cpu_cnt++;
        fifo_after = 0;
        check_eq("t3_cpu_data", {24'd0, e[7:0]}, 32'h5A);
      end else begin
        check_eq("t3_fifo_wr", {6'd0, e}, {6'd0, 18'h10040 + 18'(fifo_cnt), 8'hC0 + 8'(fifo_cnt)});
        fifo_cnt++;
        fifo_after++;
      end
    end
    check_eq("t3_cpu_seen", {31'd0, cpu_cnt > 0}, 32'd1);
    check_eq("t3_fifo_n", fifo_cnt, 32'd4);
    check_eq("t3_resume", {31'd0, fifo_after > 0}, 32'd1);
    check_eq("t3_bytes", {15'd0, bytes_o}, 32'd4);

    // 4: out-of-range address drops and flags; non-ROM index is ignored
    wr_q.delete();
    new_download(8'd0);
    send_byte(8'd0, 25'h10000, 8'h11);
    tick(); tick(); tick();
    check_eq("t4_ovf_set", {31'd0, ovf_o}, 32'd1);
    check_eq("t4_bytes0", {15'd0, bytes_o}, 32'd0);
    check_eq("t4_nowr", wr_q.size(), 32'd0);
    send_byte(8'd0, 25'h5, 8'h22);
    drain("t4_drain");
    check_eq("t4_ovf_sticky", {31'd0, ovf_o}, 32'd1);
    check_eq("t4_bytes1", {15'd0, bytes_o}, 32'd1);
    check_eq("t4_wr", {6'd0, wr_at(0)}, {6'd0, 18'h00005, 8'h22});
    wr_q.delete();
    new_download(8'd0);
    check_eq("t4_ovf_clr", {31'd0, ovf_o}, 32'd0);
    check_eq("t4_bytes_clr", {15'd0, bytes_o}, 32'd0);
    send_byte(8'd2, 25'h6, 8'h33);
    tick(); tick(); tick(); tick();
    check_eq("t4_idx2_ovf", {31'd0, ovf_o}, 32'd0);
    check_eq("t4_idx2_nowr", wr_q.size(), 32'd0);
    check_eq("t4_idx2_bytes", {15'd0, bytes_o}, 32'd0);

    // 5: reset mid-burst with 5 bytes queued
    sd_rdy = 1'b0;
    new_download(8'd1);
    for (int i = 0; i < 5; i++) send_byte(8'd1, 25'h50 + 25'(i), 8'h50 + 8'(i));
    check_eq("t5_busy_pre", {31'd0, busy_o}, 32'd1);
    wr_q.delete();
    reset_n = 1'b0; dl_active = 1'b0; sd_rdy = 1'b1;
    tick(); tick(); tick();
    check_eq("t5_wait", {31'd0, dl_wait_o}, 32'd1);
    check_eq("t5_we", {31'd0, sd_we_o}, 32'd0);
    check_eq("t5_busy", {31'd0, busy_o}, 32'd0);
    check_eq("t5_ovf", {31'd0, ovf_o}, 32'd0);
    reset_n = 1'b1;
    tick(); tick(); tick();
    check_eq("t5_nowr", wr_q.size(), 32'd0);
    check_eq("t5_wait_rel", {31'd0, dl_wait_o}, 32'd0);
    new_download(8'd1);
    for (int i = 0; i < 3; i++) send_thr(8'd1, 25'h60 + 25'(i), 8'h70 + 8'(i));
    drain("t5_drain");
    check_eq("t5_nwr", wr_q.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      check_eq("t5_wr", {6'd0, wr_at(i)}, {6'd0, 18'h10060 + 18'(i), 8'h70 + 8'(i)});
    check_eq("t5_bytes", {15'd0, bytes_o}, 32'd3);

    // 6: push and pop in one cycle at count 7, order kept across pointer wrap
    wr_q.delete();
    sd_rdy = 1'b0;
    new_download(8'd1);
    for (int i = 0; i < 7; i++) send_byte(8'd1, 25'h80 + 25'(i), 8'h90 + 8'(i));
    check_eq("t6_count7", {28'd0, dut.u_fifo.count_o}, 32'd7);
    check_eq("t6_wait7", {31'd0, dl_wait_o}, 32'd1);
    sd_rdy = 1'b1;
    send_byte(8'd1, 25'h87, 8'h97);
    check_eq("t6_count_pp", {28'd0, dut.u_fifo.count_o}, 32'd7);
    check_eq("t6_ovf", {31'd0, ovf_o}, 32'd0);
    drain("t6_drain");
    check_eq("t6_nwr", wr_q.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      check_eq("t6_wr", {6'd0, wr_at(i)}, {6'd0, 18'h10080 + 18'(i), 8'h90 + 8'(i)});
    check_eq("t6_bytes", {15'd0, bytes_o}, 32'd8);
    check_eq("t6_ovf_end", {31'd0, ovf_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
